ntt_host_responder: RTL and testbench

// - Core-side responder for the serial NTT host interface (load_a/b, start_*, read_a, din/dout, done).
// - Drop-in stand-in for the NTT processing element: banks two 256-coefficient polys, runs a cheap

---
 rtl/ntt_host_responder.sv | 141 ++++++++++++++
 tb/tb_ntt_host_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ntt_host_responder.sv
// Serial-host stand-in for the NTT core: two coefficient banks, load/read streaming, dummy operations with done.
// Optional modular-add pointwise op enabled by defining RESP_MODADD_EN.
module ntt_host_responder #(
  parameter int N      = 256,
  parameter int COEF_W = 12,
  parameter int Q      = 3329,
  parameter int OP_LAT = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_a_f,
  input  logic              load_a_i,
  input  logic              load_b_f,
  input  logic              load_b_i,
  input  logic              read_a,
  input  logic              start_fntt,
  input  logic              start_intt,
  input  logic              start_pwm2,
  input  logic [COEF_W-1:0] din,
  output logic [COEF_W-1:0] dout,
  output logic              done,
  output logic              busy_o,
  output logic              err_o
);
  localparam int LOG2N = $clog2(N);
  localparam int CNT_W = LOG2N + 1;
`ifdef RESP_MODADD_EN
  localparam bit MODADD_EN = 1'b1;
`else
  localparam bit MODADD_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, OP, WAIT, READ} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              inv_addr;
  logic              pwm_op;
  logic [COEF_W-1:0] a_mem [N];
  logic [COEF_W-1:0] b_mem [N];
  logic [LOG2N-1:0]  idx;
  logic [LOG2N-1:0]  waddr;
  logic [7:0]        cmds;
  logic              multi_cmd;
  logic [COEF_W:0]   sum;
  logic [COEF_W:0]   sum_red;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] x);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int unsigned k = 0; k < LOG2N; k++) r[k] = x[LOG2N-1-k];
    return r;
  endfunction

  assign idx       = cnt[LOG2N-1:0];
  assign waddr     = inv_addr ? bitrev(idx) : idx;
  assign cmds      = {load_a_f, load_a_i, load_b_f, load_b_i, start_fntt, start_intt, start_pwm2, read_a};
  assign multi_cmd = $countones(cmds) > 1;
  assign busy_o    = (state != IDLE);

  always_comb begin
    sum = {1'b0, a_mem[idx]} + {1'b0, b_mem[idx]};
    if (sum >= (COEF_W+1)'(Q)) sum_red = sum - (COEF_W+1)'(Q);
    else                       sum_red = sum;
  end

  // Bank storage kept out of the reset path so contents survive reset.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && state == LOAD_A)         a_mem[waddr] <= din;
    else if (rst_n_i && state == OP && pwm_op) a_mem[idx] <= sum_red[COEF_W-1:0];
    if (rst_n_i && state == LOAD_B)         b_mem[waddr] <= din;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      cnt      <= '0;
      dout     <= '0;
      done     <= 1'b0;
      err_o    <= 1'b0;
      inv_addr <= 1'b0;
      pwm_op   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && cmds != '0) err_o <= 1'b1;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (multi_cmd) err_o <= 1'b1;
          if (load_a_f || load_a_i) begin
            state    <= LOAD_A;
            inv_addr <= !load_a_f;
          end else if (load_b_f || load_b_i) begin
            state    <= LOAD_B;
            inv_addr <= !load_b_f;
          end else if (start_fntt || start_intt || start_pwm2) begin
            state  <= OP;
            pwm_op <= MODADD_EN && !start_fntt && !start_intt;
          end else if (read_a) begin
            state <= READ;
            dout  <= a_mem[0];
          end
        end
        LOAD_A, LOAD_B: begin
          if (cnt == CNT_W'(N-1)) begin
            state <= IDLE;
            cnt   <= '0;
          end else cnt <= cnt + CNT_W'(1);
        end
        OP: begin
          if (cnt == CNT_W'(N-1)) begin
            cnt <= '0;
            if (OP_LAT == 0) begin
              state <= IDLE;
              done  <= 1'b1;
            end else state <= WAIT;
          end else cnt <= cnt + CNT_W'(1);
        end
        WAIT: begin
          if (cnt == CNT_W'(OP_LAT-1)) begin
            state <= IDLE;
            done  <= 1'b1;
            cnt   <= '0;
          end else cnt <= cnt + CNT_W'(1);
        end
        READ: begin
          // dout runs one index ahead of cnt so A[0] appears the cycle after read_a.
          if (cnt == CNT_W'(N-1)) begin
            state <= IDLE;
            dout  <= '0;
            cnt   <= '0;
          end else begin
            dout <= a_mem[idx + LOG2N'(1)];
            cnt  <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ntt_host_responder.sv
// Scoreboard bench for ntt_host_responder: reference banks modelled as int arrays, monitor checks dout/done.
module tb_ntt_host_responder;
  localparam int N      = 256;
  localparam int COEF_W = 12;
  localparam int Q      = 3329;
  localparam int OP_LAT = 16;
  localparam int LOG2N  = $clog2(N);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic load_a_f = 0, load_a_i = 0, load_b_f = 0, load_b_i = 0;
  logic read_a = 0, start_fntt = 0, start_intt = 0, start_pwm2 = 0;
  logic [COEF_W-1:0] din = '0;
  logic [COEF_W-1:0] dout;
  logic done, busy_o, err_o;

  ntt_host_responder #(.N(N), .COEF_W(COEF_W), .Q(Q), .OP_LAT(OP_LAT)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .load_a_f(load_a_f), .load_a_i(load_a_i), .load_b_f(load_b_f), .load_b_i(load_b_i),
    .read_a(read_a), .start_fntt(start_fntt), .start_intt(start_intt), .start_pwm2(start_pwm2),
    .din(din), .dout(dout), .done(done), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int done_q[$];
  int ref_a[N];
  int ref_b[N];
  int stim[N];
  int rd_left = 0;
  bit mon_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int rev(input int x);
    int r = 0;
    for (int k = 0; k < LOG2N; k++) begin
      r = r * 2 + x % 2;
      x = x / 2;
    end
    return r;
  endfunction

  // Monitor: compares dout against queued read data and done against expected cycles.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rd_left > 0) begin
        chk("dout_read", 32'(dout), exp_q.size() > 0 ? exp_q.pop_front() : -1);
        rd_left--;
      end else begin
        chk("dout_idle", 32'(dout), 0);
      end
      if (done === 1'b1) chk("done_time", cyc, done_q.size() > 0 ? done_q.pop_front() : -1);
      else if (done_q.size() > 0 && done_q[0] < cyc) chk("done_missing", cyc, done_q.pop_front());
      if (rst_n && read_a && !busy_o && !load_a_f && !load_a_i && !load_b_f && !load_b_i &&
          !start_fntt && !start_intt && !start_pwm2)
        rd_left = N;
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_load(input bit bank_b, input bit inv, input int glitch_at, input bit with_read);
    if (!bank_b) begin load_a_f = !inv; load_a_i = inv; end
    else begin load_b_f = !inv; load_b_i = inv; end
    read_a = with_read;
    @(posedge clk); #1;
    load_a_f = 0; load_a_i = 0; load_b_f = 0; load_b_i = 0; read_a = 0;
    din = COEF_W'(stim[0]);
    for (int i = 0; i < N; i++) begin
      if (i == glitch_at) start_fntt = 1;
      @(posedge clk); #1;
      start_fntt = 0;
      din = (i + 1 < N) ? COEF_W'(stim[i+1]) : COEF_W'($urandom);
    end
    for (int i = 0; i < N; i++) begin
      if (!bank_b) ref_a[inv ? rev(i) : i] = stim[i] % 4096;
      else         ref_b[inv ? rev(i) : i] = stim[i] % 4096;
    end
  endtask

  task automatic do_read();
    for (int i = 0; i < N; i++) exp_q.push_back(ref_a[i]);
    read_a = 1;
    @(posedge clk); #1;
    read_a = 0;
    repeat (N) @(posedge clk);
    #1;
  endtask

  task automatic do_op(input int kind);
    int s;
    start_fntt = (kind == 0);
    start_intt = (kind == 1);
    start_pwm2 = (kind == 2);
    @(posedge clk); #1;
    start_fntt = 0; start_intt = 0; start_pwm2 = 0;
    done_q.push_back(cyc + N + OP_LAT);
`ifdef RESP_MODADD_EN
    if (kind == 2)
      for (int i = 0; i < N; i++) begin
        s = ref_a[i] + ref_b[i];
        ref_a[i] = (s >= Q ? s - Q : s) % 4096;
      end
`else
    s = 0;
`endif
    repeat (N + OP_LAT) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at %0d", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    mon_en = 1;
    chk("reset_dout", 32'(dout), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_busy", 32'(busy_o), 0);
    chk("reset_err", 32'(err_o), 0);

    // Natural-order load then readback.
    for (int i = 0; i < N; i++) stim[i] = i;
    do_load(0, 0, -1, 0);
    do_read();
    chk("err_after_clean_ops", 32'(err_o), 0);

    // Bit-reversed load.
    do_load(0, 1, -1, 0);
    do_read();

    // A=i, B=Q-1, pointwise op, read issued in the done cycle.
    for (int i = 0; i < N; i++) stim[i] = i;
    do_load(0, 0, -1, 0);
    for (int i = 0; i < N; i++) stim[i] = Q - 1;
    do_load(1, 0, -1, 0);
    do_op(2);
    do_read();

    // Random residues, B bit-reversed.
    for (int i = 0; i < N; i++) stim[i] = $urandom_range(Q - 1, 0);
    do_load(0, 0, -1, 0);
    for (int i = 0; i < N; i++) stim[i] = $urandom_range(Q - 1, 0);
    do_load(1, 1, -1, 0);
    do_op(2);
    do_read();

    // Raw 12-bit values through identity ops.
    for (int i = 0; i < N; i++) stim[i] = $urandom_range(4095, 0);
    do_load(0, 0, -1, 0);
    do_op(0);
    do_op(1);
    do_read();
    chk("err_still_clear", 32'(err_o), 0);

    // start_fntt mid-load is ignored but flags err.
    for (int i = 0; i < N; i++) stim[i] = $urandom_range(4095, 0);
    do_load(0, 1, 10, 0);
    chk("err_cmd_while_busy", 32'(err_o), 1);
    chk("busy_after_load", 32'(busy_o), 0);
    do_read();
    chk("err_sticky", 32'(err_o), 1);
    do_reset();
    chk("err_cleared_by_reset", 32'(err_o), 0);

    // Simultaneous load_a_f and read_a: load wins.
    for (int i = 0; i < N; i++) stim[i] = $urandom_range(4095, 0);
    do_load(0, 0, -1, 1);
    chk("err_multi_cmd", 32'(err_o), 1);
    do_read();
    do_reset();

    // Reset mid-operation aborts without done.
    start_fntt = 1;
    @(posedge clk); #1;
    start_fntt = 0;
    repeat (99) @(posedge clk);
    #1;
    chk("busy_during_op", 32'(busy_o), 1);
    rst_n = 0;
    @(posedge clk); #1;
    chk("busy_after_abort", 32'(busy_o), 0);
    rst_n = 1;
    repeat (300) @(posedge clk);
    #1;
    chk("err_after_abort", 32'(err_o), 0);

    chk("read_queue_drained", exp_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
